// File: rtl/alu_command_sequencer.sv
// alu_command_sequencer
// Issues a host-loaded program of {op_code, operand} words to the 16-bit
// accumulator ALU. Each instruction gets one ISSUE cycle followed by one
// CAPTURE cycle in which the ALU sees NO-OP. The sequencer flags
// divide-by-zero before issue, records add/sub overflow, and hands the final
// accumulator value back to the host.
module alu_command_sequencer #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter bit HALT_ON_ERROR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_wr,
  input  logic [AW-1:0] prog_addr,
  input  logic [19:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [3:0]    alu_op_code,
  output logic [15:0]   alu_inputA,
  input  logic [31:0]   alu_result,
  input  logic          alu_error,
  output logic [31:0]   result,
  output logic [1:0]    err_flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0001;
  localparam logic [3:0] OP_NOP = 4'b1101;
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   a_q, a_d;
  logic [31:0]   result_q, result_d;
  logic [1:0]    err_q, err_d;
  logic [AW:0]   len_q, len_d;
  logic          hit_q, hit_d;

  logic [19:0]   mem_q [DEPTH];

  logic [19:0]   fetch0_s;
  logic [19:0]   fetch_next_s;
  logic [AW-1:0] pc_inc_s;
  logic [AW:0]   len_sat_s;
  logic          last_s;
  logic          ovf_s;
  logic          dz_s;

  // Program store: host writes land only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_wr && (state_q == S_IDLE)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Fetch paths and error detection; entry 0 forwards a same-edge host write.
  always_comb begin
    fetch0_s     = (prog_wr && (prog_addr == {AW{1'b0}})) ? prog_data : mem_q[0];
    pc_inc_s     = pc_q + PC_ONE;
    fetch_next_s = mem_q[pc_inc_s];
    len_sat_s    = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    last_s       = ({1'b0, pc_q} == (len_q - LEN_ONE));
    ovf_s        = alu_error && ((op_q == OP_ADD) || (op_q == OP_SUB));
    // Divisor is the pre-issue accumulator, i.e. the ALU's current inputB.
    dz_s         = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (alu_result[15:0] == 16'h0000);
  end

  // Next-state and next-output logic of the run controller.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pc_d     = pc_q;
    op_d     = OP_NOP;
    a_d      = a_q;
    result_d = result_q;
    err_d    = err_q;
    len_d    = len_q;
    hit_d    = hit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_len == {(AW+1){1'b0}}) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            busy_d  = 1'b1;
            err_d   = 2'b00;
            pc_d    = {AW{1'b0}};
            len_d   = len_sat_s;
            hit_d   = 1'b0;
            op_d    = fetch0_s[19:16];
            a_d     = fetch0_s[15:0];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // The ALU register captures the new accumulator at this same edge.
        err_d   = err_q | {dz_s, ovf_s};
        hit_d   = dz_s | ovf_s;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_d = alu_result;
        if ((HALT_ON_ERROR && hit_q) || last_s) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
          pc_d    = pc_inc_s;
          op_d    = fetch_next_s[19:16];
          a_d     = fetch_next_s[15:0];
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pc_q     <= {AW{1'b0}};
      op_q     <= OP_NOP;
      a_q      <= 16'h0000;
      result_q <= 32'h0000_0000;
      err_q    <= 2'b00;
      len_q    <= {(AW+1){1'b0}};
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      a_q      <= a_d;
      result_q <= result_d;
      err_q    <= err_d;
      len_q    <= len_d;
      hit_q    <= hit_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pc          = pc_q;
  assign alu_op_code = op_q;
  assign alu_inputA  = a_q;
  assign result      = result_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_alu_command_sequencer.sv
// Bench for alu_command_sequencer: two instances (halting and continuing on
// error) share the host inputs; each drives its own behavioural ALU. An
// instruction-level model predicts per-cycle op codes and final results.
module tb_alu_command_sequencer;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_wr = 1'b0;
  logic [3:0]        prog_addr = 4'd0;
  logic [19:0]       prog_data = 20'd0;
  logic [4:0]        prog_len = 5'd0;
  logic              start = 1'b0;
  logic              alu_err_drv = 1'b0;
  logic [1:0]        busy_o, done_o;
  logic [1:0][3:0]   pc_o, op_o;
  logic [1:0][15:0]  a_o;
  logic [1:0][31:0]  res_o;
  logic [1:0][1:0]   err_o;
  logic [1:0][31:0]  alu_res = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // bench copy of program memory and per-instance model state
  logic [19:0] prog [16];
  logic [31:0] m_res [2];
  logic [1:0]  m_err [2];
  logic [3:0]  m_pc  [2];
  int          n_instr [2];
  int          done_at [2];
  logic [3:0]  trace0 [40];

  always #5 clk = ~clk;

  alu_command_sequencer #(.DEPTH(16), .AW(4), .HALT_ON_ERROR(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .prog_wr(prog_wr), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .busy(busy_o[0]), .done(done_o[0]), .pc(pc_o[0]),
    .alu_op_code(op_o[0]), .alu_inputA(a_o[0]),
    .alu_result(alu_res[0]), .alu_error(alu_err_drv),
    .result(res_o[0]), .err_flags(err_o[0]));

  alu_command_sequencer #(.DEPTH(16), .AW(4), .HALT_ON_ERROR(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .prog_wr(prog_wr), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .busy(busy_o[1]), .done(done_o[1]), .pc(pc_o[1]),
    .alu_op_code(op_o[1]), .alu_inputA(a_o[1]),
    .alu_result(alu_res[1]), .alu_error(alu_err_drv),
    .result(res_o[1]), .err_flags(err_o[1]));

  // Behavioural accumulator ALU; inputB is the low half of its own register.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [31:0] acc);
    logic [15:0] b;
    b = acc[15:0];
    case (op)
      4'h0: alu_f = {16'h0000, a + b};
      4'h8: alu_f = {16'h0000, b - a};
      4'h4: alu_f = 32'(a) * 32'(b);
      4'h2: alu_f = (b == 16'h0000) ? 32'hFFFF_FFFF : 32'(a / b);
      4'h1: alu_f = (b == 16'h0000) ? 32'hFFFF_FFFF : 32'(a % b);
      4'h3: alu_f = 32'h0000_0000;
      4'h7: alu_f = {16'h0000, a};
      4'h5: alu_f = {16'h0000, a & b};
      default: alu_f = acc;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_res[0] <= alu_f(op_o[0], a_o[0], alu_res[0]);
    alu_res[1] <= alu_f(op_o[1], a_o[1], alu_res[1]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction-level prediction for instance i (i==0 halts on error).
  task automatic predict(input int i, input int len);
    int          len_eff;
    logic [31:0] acc;
    logic [3:0]  op;
    logic        ov, dz;
    len_eff = (len > 16) ? 16 : len;
    acc = alu_res[i];
    n_instr[i] = 0;
    if (len_eff > 0) m_err[i] = 2'b00;
    for (int k = 0; k < len_eff; k++) begin
      op = prog[k][19:16];
      ov = alu_err_drv && (op == 4'h0 || op == 4'h8);
      dz = (op == 4'h2 || op == 4'h1) && (acc[15:0] == 16'h0000);
      m_err[i] = m_err[i] | {dz, ov};
      acc = alu_f(op, prog[k][15:0], acc);
      n_instr[i]++;
      m_pc[i] = 4'(k);
      m_res[i] = acc;
      if (i == 0 && (ov || dz)) break;
    end
  endtask

  task automatic wr(input logic [3:0] ad, input logic [19:0] d);
    @(negedge clk);
    prog_wr = 1'b1; prog_addr = ad; prog_data = d;
    @(posedge clk);
    #1 prog_wr = 1'b0;
    prog[ad] = d;
  endtask

  // Start a run and compare both instances against the model every cycle.
  task automatic run(input logic [4:0] len, input bit wr0, input logic [19:0] wd);
    int maxc, k;
    logic [3:0] eop;
    if (wr0) prog[0] = wd;
    predict(0, int'(len));
    predict(1, int'(len));
    done_at[0] = 0; done_at[1] = 0;
    maxc = 2 * ((n_instr[0] > n_instr[1]) ? n_instr[0] : n_instr[1]) + 3;
    @(negedge clk);
    start = 1'b1; prog_len = len;
    if (wr0) begin prog_wr = 1'b1; prog_addr = 4'd0; prog_data = wd; end
    @(posedge clk);
    #1 start = 1'b0; prog_wr = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c < 40) trace0[c-1] = op_o[0];
      for (int i = 0; i < 2; i++) begin
        k = (c - 1) / 2;
        eop = (c <= 2 * n_instr[i] && (c % 2) == 1) ? prog[k][19:16] : 4'hD;
        chk($sformatf("op i%0d c%0d", i, c), 32'(op_o[i]), 32'(eop));
        chk($sformatf("busy i%0d c%0d", i, c), 32'(busy_o[i]), 32'(c <= 2 * n_instr[i]));
        chk($sformatf("done i%0d c%0d", i, c), 32'(done_o[i]), 32'(c == 2 * n_instr[i] + 1));
        if (c <= 2 * n_instr[i] && (c % 2) == 1)
          chk($sformatf("inA i%0d c%0d", i, c), 32'(a_o[i]), 32'(prog[k][15:0]));
        if (done_o[i] && done_at[i] == 0) done_at[i] = c;
        if (c == 2 * n_instr[i] + 1) begin
          chk($sformatf("pc i%0d", i), 32'(pc_o[i]), 32'(m_pc[i]));
          chk($sformatf("result i%0d", i), res_o[i], m_res[i]);
          chk($sformatf("err i%0d", i), 32'(err_o[i]), 32'(m_err[i]));
        end
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s busy i%0d", tag, i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("%s done i%0d", tag, i), 32'(done_o[i]), 32'd0);
      chk($sformatf("%s pc i%0d", tag, i), 32'(pc_o[i]), 32'd0);
      chk($sformatf("%s op i%0d", tag, i), 32'(op_o[i]), 32'hD);
      chk($sformatf("%s inA i%0d", tag, i), 32'(a_o[i]), 32'd0);
      chk($sformatf("%s result i%0d", tag, i), res_o[i], 32'd0);
      chk($sformatf("%s err i%0d", tag, i), 32'(err_o[i]), 32'd0);
      m_res[i] = 32'd0; m_err[i] = 2'b00; m_pc[i] = 4'd0;
    end
  endtask

  initial begin
    logic [3:0] seq1 [8];
    seq1 = '{4'h3, 4'hD, 4'h0, 4'hD, 4'h0, 4'hD, 4'h4, 4'hD};
    for (int i = 0; i < 16; i++) prog[i] = 20'h0;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: RESET, ADD 6, ADD 6, MUL 6
    wr(4'd0, {4'h3, 16'd0}); wr(4'd1, {4'h0, 16'd6});
    wr(4'd2, {4'h0, 16'd6}); wr(4'd3, {4'h4, 16'd6});
    for (int i = 0; i < 16; i++) wr(4'(i), prog[i]);
    run(5'd4, 1'b0, 20'h0);
    for (int c = 0; c < 8; c++) chk($sformatf("t1 seq c%0d", c + 1), 32'(trace0[c]), 32'(seq1[c]));
    chk("t1 result", res_o[0], 32'd72);
    chk("t1 err", 32'(err_o[0]), 32'd0);
    chk("t1 done_at", 32'(done_at[0]), 32'd9);

    // 2/3: divide by zero, halting vs continuing
    wr(4'd0, {4'h3, 16'd0}); wr(4'd1, {4'h2, 16'd6}); wr(4'd2, {4'h0, 16'd6});
    run(5'd3, 1'b0, 20'h0);
    chk("t2 err", 32'(err_o[0]), 32'd2);
    chk("t2 pc", 32'(pc_o[0]), 32'd1);
    chk("t2 result", res_o[0], 32'hFFFF_FFFF);
    chk("t2 done_at", 32'(done_at[0]), 32'd5);
    chk("t3 err", 32'(err_o[1]), 32'd2);
    chk("t3 result", res_o[1], 32'h0000_0005);
    chk("t3 done_at", 32'(done_at[1]), 32'd7);

    // 4: overflow flag counts only for ADD/SUB
    alu_err_drv = 1'b1;
    wr(4'd0, {4'h7, 16'd0}); wr(4'd1, {4'h5, 16'd5}); wr(4'd2, {4'h0, 16'd1});
    run(5'd3, 1'b0, 20'h0);
    chk("t4 err h", 32'(err_o[0]), 32'd1);
    chk("t4 err c", 32'(err_o[1]), 32'd1);
    chk("t4 pc h", 32'(pc_o[0]), 32'd2);
    wr(4'd0, {4'h5, 16'd3});
    run(5'd1, 1'b0, 20'h0);
    chk("t4 and err", 32'(err_o[0]), 32'd0);
    alu_err_drv = 1'b0;

    // 5: zero-length run
    run(5'd0, 1'b0, 20'h0);
    chk("t5 done_at h", 32'(done_at[0]), 32'd1);
    chk("t5 done_at c", 32'(done_at[1]), 32'd1);

    // write to entry 0 on the start edge is seen by the run
    run(5'd1, 1'b1, {4'h7, 16'h0042});
    chk("wr+start result", res_o[0], 32'h0000_0042);

    // prog_len above DEPTH saturates
    wr(4'd0, {4'h3, 16'd0});
    for (int i = 1; i < 16; i++) wr(4'(i), {4'h0, 16'd1});
    run(5'd20, 1'b0, 20'h0);
    chk("sat result", res_o[0], 32'd15);
    chk("sat pc", 32'(pc_o[0]), 32'd15);
    chk("sat done_at", 32'(done_at[0]), 32'd33);

    // 6: ignored write while busy, then reset in the second ISSUE
    wr(4'd0, {4'h3, 16'd0}); wr(4'd1, {4'h0, 16'd6}); wr(4'd2, {4'h0, 16'd6});
    @(negedge clk);
    start = 1'b1; prog_len = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    prog_wr = 1'b1; prog_addr = 4'd1; prog_data = {4'h0, 16'd99};
    @(posedge clk);
    #1 prog_wr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrun");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("no done c%0d", c), 32'(done_o), 32'd0);
    end
    rst_n = 1'b1;
    run(5'd2, 1'b0, 20'h0);
    chk("readback result", res_o[0], 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
